entropy_encode_ac_level_stream: RTL and testbench



---
 rtl/entropy_encode_ac_level_stream.sv | 213 +++++++++++++++++++++
 tb/tb_entropy_encode_ac_level_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_encode_ac_level_stream.sv
`default_nettype none
// ============================================================================
// Module   : entropy_encode_ac_level_stream
// Purpose  : Three-stage adaptive Rice/exp-Golomb AC level encoder with a
//            valid/ready handshake, block restart and saturation reporting.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_encode_ac_level_stream #(
    parameter int COEFF_W = 20,
    parameter int CODE_W  = 48,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_last,
    output logic               out_sat
);
    localparam int c_MAG_W = COEFF_W - 1;
    localparam int c_BL_W  = $clog2(COEFF_W + 1);
    localparam logic [c_MAG_W-1:0] c_MAG_ONE = c_MAG_W'(1);

    logic w_adv;
    logic r_out_valid;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: magnitude, sign, clamp, codebook select, adaptation state
    // ------------------------------------------------------------------
    logic               w_sign, w_sat, w_zero;
    logic [c_MAG_W-1:0] w_abs, w_n;
    logic [3:0]         w_n_clip, w_prev_eff;
    logic [1:0]         w_limit, w_k;
    logic [3:0]         r_prev;
    logic               r_pend_first;

    always_comb begin
        w_sign = in_coeff[COEFF_W-1];
        w_sat  = w_sign && (in_coeff[c_MAG_W-1:0] == '0);
        // The most negative code has no positive twin; clamp to the largest magnitude.
        if (w_sat) begin
            w_abs = '1;
        end else if (w_sign) begin
            w_abs = ~in_coeff[c_MAG_W-1:0] + c_MAG_ONE;
        end else begin
            w_abs = in_coeff[c_MAG_W-1:0];
        end
        w_zero     = (w_abs == '0);
        w_n        = w_abs - c_MAG_ONE;
        w_n_clip   = (w_n >= c_MAG_W'(8)) ? 4'd8 : w_n[3:0];
        w_prev_eff = (in_first || r_pend_first) ? 4'd1 : r_prev;
        w_limit    = 2'd0;
        w_k        = 2'd2;
        case (w_prev_eff)
            4'd0:    begin w_limit = 2'd3; w_k = 2'd2; end
            4'd1:    begin w_limit = 2'd2; w_k = 2'd1; end
            4'd2:    begin w_limit = 2'd3; w_k = 2'd1; end
            4'd3:    begin w_limit = 2'd0; w_k = 2'd0; end
            4'd4, 4'd5, 4'd6, 4'd7:
                     begin w_limit = 2'd0; w_k = 2'd1; end
            default: begin w_limit = 2'd0; w_k = 2'd2; end
        endcase
    end

    logic               r1_valid, r1_zero, r1_sign, r1_last, r1_sat;
    logic [c_MAG_W-1:0] r1_n;
    logic [1:0]         r1_limit, r1_k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev       <= 4'd1;
            r_pend_first <= 1'b1;
            r1_valid     <= 1'b0;
            r1_zero      <= 1'b0;
            r1_sign      <= 1'b0;
            r1_last      <= 1'b0;
            r1_sat       <= 1'b0;
            r1_n         <= '0;
            r1_limit     <= 2'd0;
            r1_k         <= 2'd0;
        end else if (w_adv) begin
            // Zero beats only travel down the pipe when they close a block.
            r1_valid <= in_valid && (!w_zero || in_last);
            r1_zero  <= w_zero;
            r1_sign  <= w_sign;
            r1_last  <= in_last;
            r1_sat   <= w_sat;
            r1_n     <= w_n;
            r1_limit <= w_limit;
            r1_k     <= w_k;
            if (in_valid) begin
                if (!w_zero) begin
                    r_prev       <= w_n_clip;
                    r_pend_first <= 1'b0;
                end else if (in_first) begin
                    r_pend_first <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: escape decision, exp-Golomb value and its bit length
    // ------------------------------------------------------------------
    logic               w2_esc;
    logic [c_MAG_W-1:0] w2_m;
    logic [COEFF_W-1:0] w2_v;
    logic [c_BL_W-1:0]  w2_b;

    always_comb begin
        w2_esc = (r1_n >= c_MAG_W'(r1_limit));
        w2_m   = r1_n - c_MAG_W'(r1_limit);
        w2_v   = {1'b0, w2_m} + (COEFF_W'(1) << r1_k);
        w2_b   = '0;
        for (int i = 0; i < COEFF_W; i++) begin
            if (w2_v[i]) begin
                w2_b = c_BL_W'(i + 1);
            end
        end
    end

    logic               r2_valid, r2_zero, r2_esc, r2_sign, r2_last, r2_sat;
    logic [1:0]         r2_nlow, r2_limit, r2_k;
    logic [COEFF_W-1:0] r2_v;
    logic [c_BL_W-1:0]  r2_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_valid <= 1'b0;
            r2_zero  <= 1'b0;
            r2_esc   <= 1'b0;
            r2_sign  <= 1'b0;
            r2_last  <= 1'b0;
            r2_sat   <= 1'b0;
            r2_nlow  <= 2'd0;
            r2_limit <= 2'd0;
            r2_k     <= 2'd0;
            r2_v     <= '0;
            r2_b     <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_zero  <= r1_zero;
            r2_esc   <= w2_esc;
            r2_sign  <= r1_sign;
            r2_last  <= r1_last;
            r2_sat   <= r1_sat;
            r2_nlow  <= r1_n[1:0];
            r2_limit <= r1_limit;
            r2_k     <= r1_k;
            r2_v     <= w2_v;
            r2_b     <= w2_b;
        end
    end

    // ------------------------------------------------------------------
    // S3: codeword assembly. Leading zeros are implicit in right alignment,
    // so only the terminating one / exp-Golomb value and sign carry bits.
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] w3_code;
    logic [LEN_W-1:0]  w3_len;

    always_comb begin
        w3_code = '0;
        w3_len  = '0;
        if (r2_valid && !r2_zero) begin
            if (r2_esc) begin
                w3_code = CODE_W'({r2_v, r2_sign});
                w3_len  = LEN_W'(r2_limit) + LEN_W'({r2_b, 1'b0}) - LEN_W'(r2_k);
            end else begin
                w3_code = CODE_W'({1'b1, r2_sign});
                w3_len  = LEN_W'(r2_nlow) + LEN_W'(2);
            end
        end
    end

    logic [CODE_W-1:0] r_out_code;
    logic [LEN_W-1:0]  r_out_len;
    logic              r_out_last, r_out_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_out_code  <= w3_code;
            r_out_len   <= w3_len;
            r_out_last  <= r2_valid && r2_last;
            r_out_sat   <= r2_valid && r2_sat;
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_len   = r_out_len;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_entropy_encode_ac_level_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_entropy_encode_ac_level_stream
// Purpose  : Self-checking bench: vector table, reference model, scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entropy_encode_ac_level_stream;
    localparam int COEFF_W = 20;
    localparam int CODE_W  = 48;
    localparam int LEN_W   = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b1;
    logic [COEFF_W-1:0] in_coeff = '0;
    logic               in_ready, out_valid, out_last, out_sat;
    logic [CODE_W-1:0]  out_code;
    logic [LEN_W-1:0]   out_len;

    always #5 clk = ~clk;

    entropy_encode_ac_level_stream #(
        .COEFF_W(COEFF_W), .CODE_W(CODE_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_len(out_len), .out_last(out_last), .out_sat(out_sat)
    );

    typedef struct {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
        logic              last;
        logic              sat;
    } exp_t;

    typedef struct {
        logic [COEFF_W-1:0] coeff;
        bit                 first;
        bit                 last;
        bit                 emit;
        exp_t               exp;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    exp_t mon_e;
    exp_t nox;
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;
    int   m_prev = 1;
    bit   m_pend = 1'b1;
    bit   rnd_on = 1'b0;

    // Bit-serial reference encoder; tracks its own adaptation state.
    function automatic void model(input logic [COEFF_W-1:0] c, input bit f, input bit l,
                                  output bit emit, output exp_t e);
        int val, n, lim, k, m, v, b, pe, len;
        longint unsigned code;
        val    = c[COEFF_W-1] ? int'(c) - (1 << COEFF_W) : int'(c);
        e.code = '0;
        e.len  = '0;
        e.last = l;
        e.sat  = (val == -(1 << (COEFF_W - 1)));
        emit   = 1'b0;
        if (e.sat) val = -((1 << (COEFF_W - 1)) - 1);
        if (val == 0) begin
            emit = l;
            if (f) m_pend = 1'b1;
            return;
        end
        emit = 1'b1;
        n  = (val < 0 ? -val : val) - 1;
        pe = (f || m_pend) ? 1 : m_prev;
        if (pe == 0)      begin lim = 3; k = 2; end
        else if (pe == 1) begin lim = 2; k = 1; end
        else if (pe == 2) begin lim = 3; k = 1; end
        else if (pe == 3) begin lim = 0; k = 0; end
        else if (pe < 8)  begin lim = 0; k = 1; end
        else              begin lim = 0; k = 2; end
        code = 0;
        len  = 0;
        if (n < lim) begin
            for (int i = 0; i < n; i++) begin code = code << 1; len++; end
            code = (code << 1) | 64'd1; len++;
        end else begin
            for (int i = 0; i < lim; i++) begin code = code << 1; len++; end
            m = n - lim;
            v = m + (1 << k);
            b = 0;
            while ((v >> b) != 0) b++;
            for (int i = 0; i < b - 1 - k; i++) begin code = code << 1; len++; end
            for (int i = b - 1; i >= 0; i--) begin
                code = (code << 1) | longint'((v >> i) & 1);
                len++;
            end
        end
        code   = (code << 1) | longint'(val < 0);
        len++;
        e.code = code[CODE_W-1:0];
        e.len  = len[LEN_W-1:0];
        m_prev = (n > 8) ? 8 : n;
        m_pend = 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic add(input int c, input bit f, input bit l, input bit em,
                       input longint cd, input int ln, input bit s);
        vec_t v;
        v.coeff    = COEFF_W'(c);
        v.first    = f;
        v.last     = l;
        v.emit     = em;
        v.exp.code = CODE_W'(cd);
        v.exp.len  = LEN_W'(ln);
        v.exp.last = l;
        v.exp.sat  = s;
        tbl.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [COEFF_W-1:0] c, input bit f, input bit l,
                        input bit use_tbl, input bit t_emit, input exp_t t_exp);
        bit   em;
        exp_t me;
        int   n;
        in_coeff = c;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, n);
        end else begin
            model(c, f, l, em, me);
            if (use_tbl) begin
                if (t_emit) exp_q.push_back(t_exp);
            end else if (em) begin
                exp_q.push_back(me);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_m(input logic [COEFF_W-1:0] c, input bit f, input bit l);
        send(c, f, l, 1'b0, 1'b0, nox);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COEFF_W-1:0] rnd_coeff();
        int s, mag;
        s = $urandom_range(0, 9);
        if (s == 0) return '0;
        if (s == 8) return {1'b1, {(COEFF_W-1){1'b0}}};
        if (s <= 6)      mag = $urandom_range(1, 12);
        else if (s == 7) mag = $urandom_range(13, (1 << (COEFF_W - 1)) - 1);
        else             mag = $urandom_range(1, 40);
        if ($urandom_range(0, 1) == 1) mag = -mag;
        return COEFF_W'(mag);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        exp_t te;

        fork
            forever begin
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    checks++;
                    beats++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat%0d_unexpected: got code=%0h len=%0d last=%0d, required no beat",
                                 beats, out_code, out_len, out_last);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (out_code !== mon_e.code || out_len !== mon_e.len ||
                            out_last !== mon_e.last || out_sat !== mon_e.sat) begin
                            errors++;
                            $display("FAIL beat%0d: got code=%0h len=%0d last=%0d sat=%0d, required code=%0h len=%0d last=%0d sat=%0d",
                                     beats, out_code, out_len, out_last, out_sat,
                                     mon_e.code, mon_e.len, mon_e.last, mon_e.sat);
                        end
                    end
                end
            end
        join_none

        // Vector table: spec block, zero-padded block, restart, saturation,
        // zero-with-first restart, remaining codebooks.
        add(1, 1, 0, 1, 'h2, 2, 0);
        add(-3, 0, 0, 1, 'h3, 4, 0);
        add(5, 0, 0, 1, 'h6, 6, 0);
        add(10, 0, 1, 1, 'h16, 7, 0);
        add(1, 1, 0, 1, 'h2, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(-3, 0, 0, 1, 'h3, 4, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(5, 0, 0, 1, 'h6, 6, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(10, 0, 0, 1, 'h16, 7, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(9, 0, 0, 1, 'h18, 6, 0);
        add(1, 1, 1, 1, 'h2, 2, 0);
        add(-524288, 1, 1, 1, 'hFFFFD, 39, 1);
        add(0, 1, 0, 0, 0, 0, 0);
        add(-2, 0, 1, 1, 'h3, 3, 0);
        add(4, 1, 0, 1, 'h6, 5, 0);
        add(2, 0, 0, 1, 'h4, 4, 0);
        add(-6, 0, 0, 1, 'hB, 7, 0);
        add(7, 0, 1, 1, 'h10, 7, 0);
        add(1, 1, 0, 1, 'h2, 2, 0);
        add(4, 0, 1, 1, 'h8, 7, 0);

        // Reset state
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_code", out_code, 0);
        check("reset_out_len", out_len, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_sat", out_sat, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency of a lone beat
        send_m(COEFF_W'(1), 1'b1, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", lat, 3);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].coeff, tbl[i].first, tbl[i].last, 1'b1, tbl[i].emit, tbl[i].exp);
        end
        drain("drain_table");

        // Output stall while six beats are offered
        out_ready = 1'b0;
        fork
            begin
                send_m(COEFF_W'(3), 1'b1, 1'b0);
                send_m(COEFF_W'(-1), 1'b0, 1'b0);
                send_m(COEFF_W'(0), 1'b0, 1'b0);
                send_m(COEFF_W'(12), 1'b0, 1'b0);
                send_m(COEFF_W'(-7), 1'b0, 1'b0);
                send_m(COEFF_W'(100), 1'b0, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_in_ready_low", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Random bubbles and back-pressure
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send_m(rnd_coeff(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        // Reset with beats in flight
        send_m(COEFF_W'(1), 1'b1, 1'b0);
        send_m(COEFF_W'(3), 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        #1 reset = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_len", out_len, 0);
        exp_q.delete();
        m_prev = 1;
        m_pend = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        te.code = CODE_W'(2);
        te.len  = LEN_W'(2);
        te.last = 1'b1;
        te.sat  = 1'b0;
        send(COEFF_W'(1), 1'b0, 1'b1, 1'b1, 1'b1, te);
        drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
